priority_decoder_seq: RTL
=========================

Name: priority_decoder_seq

Overview:
- Receive-side counterpart of the 8-to-3 priority encoder: takes a 3-bit index (in2,in1,in0) and drives the matching one of eight one-hot lines a..h, where a is index 0 and h is index 7.
- Each accepted index asserts its line for HOLD cycles, then all lines idle low for GAP cycles.
- One index can queue in a single-entry pending buffer while a drive is in progress.
- Sits downstream of the encoder to regenerate timed select/strobe lines from an encoded request stream.

Parameters:
HOLD, 4, cycles the selected one-hot line stays high per accepted index; legal range 1..255.
GAP, 1, idle cycles (all lines low) after each drive; legal range 0..255; 0 allows back-to-back drives.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
valid  input  1  index present on in2..in0 this cycle.
in0  input  1  index bit 0 (LSB).
in1  input  1  index bit 1.
in2  input  1  index bit 2 (MSB).
ready  output  1  block can accept an index this cycle.
a  output  1  one-hot line, index 0.
b  output  1  index 1.
c  output  1  index 2.
d  output  1  index 3.
e  output  1  index 4.
f  output  1  index 5.
g  output  1  index 6.
h  output  1  index 7.
busy  output  1  high when the FSM is not IDLE.
done  output  1  one-cycle pulse on the last HOLD cycle of each drive.

Behaviour:
- Reset: rst_n low clears all state asynchronously and immediately, including mid-drive.
  - While reset is held: FSM=IDLE, pending empty, counter=0.
  - Outputs: a..h=0, busy=0, done=0, ready=1.
- Handshake: an index is accepted at a rising edge where valid=1 and ready=1.
  - ready = pending buffer empty; it is a combinational decode of registers only, never of valid.
  - in2..in0 are ignored when valid=0 or ready=0; the source must hold them.
- FSM states:
  - IDLE: a..h=0. On accept, latch the index to the current register, load counter=HOLD-1, go DRIVE. The pending buffer is bypassed.
  - DRIVE: exactly one line of a..h high, selected by the current index; all others 0. Counter decrements each cycle.
  - DRIVE exit, on the cycle the counter reaches 0: done=1 that cycle. Then:
    - if GAP>0, load counter=GAP-1 and go GAP;
    - else if pending is full, move pending to current, reload HOLD-1, stay DRIVE;
    - else go IDLE.
  - GAP: a..h=0. Counter decrements. At 0: if pending is full, move it to current, load HOLD-1, go DRIVE; else go IDLE.
- Acceptance in DRIVE/GAP: an accepted index is written to the pending buffer. Since ready=0 while pending is full, no overwrite is possible.
- Simultaneous events: if pending is consumed at the same edge a new valid arrives, ready was 0, so the new index waits. Pending becomes empty at that edge and ready returns to 1 the following cycle.
- Latency: accept at edge N puts the line high from N+1 through N+HOLD. Back-to-back indices with GAP=0 give no low cycle between drives.
- Lines a..h, busy and done are registered outputs with no combinational path from the inputs.
- The same index in successive drives keeps its line high continuously when GAP=0.
- HOLD=1: a single-cycle pulse, with done asserted in that same cycle.
- Counter width is 8 bits, with no wrap beyond the parameter range.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with valid=0 -> a..h=0, busy=0, done=0, ready=1 throughout.
- Full decode sweep (HOLD=4, GAP=1): send indices 0..7, each when ready=1.
  - Required: each index drives only its line (0->a ... 7->h) for exactly 4 cycles, then 1 low cycle.
  - done pulses once per index, on its 4th high cycle.
- Pending buffer (HOLD=4, GAP=1): accept 3, then offer 5 one cycle later.
  - Required: 5 is accepted and ready drops to 0.
  - A third index (6) is held off until 5 moves to current.
  - Waveform: d high for 4 cycles, 1 low cycle, f high for 4 cycles, 1 low cycle, then g.
- Back-to-back (HOLD=2, GAP=0): accept 1, then queue 1, then 2.
  - Required: b high for 4 consecutive cycles, immediately followed by c for 2 cycles.
  - done fires at cycles 2, 4 and 6.
- Reset mid-drive: assert rst_n=0 during the 2nd HOLD cycle of index 7.
  - Required: h falls without waiting for a clock edge; pending is cleared.
  - After release: idle, ready=1, and no stale drive appears.
- Stall integrity: toggle in2..in0 while ready=0 and valid=1 -> the pending index equals the value present at the accepting edge only.

Source files
------------

// File: rtl/priority_decoder_seq.sv
// 3-bit index to timed one-hot strobe regenerator: each accepted index drives
// its line for HOLD cycles, then GAP idle cycles, with a one-deep pending slot.
module priority_decoder_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic ready,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic h,
    output logic busy,
    output logic done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    logic [1:0] r_state;
    logic [2:0] r_cur;
    logic [7:0] r_cnt;
    logic       r_pend_vld;
    logic [2:0] r_pend;
    logic [7:0] r_lines;
    logic       r_busy;
    logic       r_done;

    logic [1:0] w_state_nxt;
    logic [2:0] w_cur_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_pend_vld_nxt;
    logic [2:0] w_pend_nxt;
    logic [2:0] w_idx;
    logic       w_acc;
    logic       w_end;

    assign w_idx = {in2, in1, in0};
    assign ready = ~r_pend_vld;
    assign w_acc = valid & ready;

    // End of a drive/gap cycle where the next queued index (if any) may start.
    assign w_end = (r_cnt == 8'd0) &&
                   ((r_state == S_GAP) || (r_state == S_DRIVE && GAP == 0));

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_cnt_nxt      = r_cnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_cur_nxt   = w_idx;
                    w_cnt_nxt   = HOLD_M1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE, S_GAP: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else if (r_state == S_DRIVE && GAP != 0) begin
                    w_cnt_nxt   = GAP_M1;
                    w_state_nxt = S_GAP;
                end else if (r_pend_vld) begin
                    w_cur_nxt      = r_pend;
                    w_cnt_nxt      = HOLD_M1;
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = S_DRIVE;
                end else if (w_acc) begin
                    // Index arriving exactly as the slot frees starts directly.
                    w_cur_nxt   = w_idx;
                    w_cnt_nxt   = HOLD_M1;
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
                if (w_acc && !w_end) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_nxt     = w_idx;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur      <= 3'd0;
            r_cnt      <= 8'd0;
            r_pend_vld <= 1'b0;
            r_pend     <= 3'd0;
            r_lines    <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend     <= w_pend_nxt;
            r_lines    <= (w_state_nxt == S_DRIVE) ? (8'd1 << w_cur_nxt) : 8'd0;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DRIVE) && (w_cnt_nxt == 8'd0);
        end
    end

    assign {h, g, f, e, d, c, b, a} = r_lines;
    assign busy = r_busy;
    assign done = r_done;

endmodule
